// File: rtl/fp_trace_packer_if.sv
// FPU execute-side observation bus plus the packed-record output stream of fp_trace_packer.
// The FPU/consumer side drives through master; the recorder sits on slave.
interface fp_trace_packer_if;
    logic         issue_valid;
    logic [31:0]  issue_data1;
    logic [31:0]  issue_data2;
    logic [31:0]  issue_data3;
    logic [2:0]   issue_rm;
    logic [1:0]   issue_op;
    logic [9:0]   issue_opcode;
    logic         cmpl_valid;
    logic [31:0]  cmpl_result;
    logic [4:0]   cmpl_flags;
    logic         rec_valid;
    logic [155:0] rec_data;
    logic         rec_ready;

    modport master (
        output issue_valid, issue_data1, issue_data2, issue_data3,
        output issue_rm, issue_op, issue_opcode,
        output cmpl_valid, cmpl_result, cmpl_flags,
        output rec_ready,
        input  rec_valid, rec_data
    );

    modport slave (
        input  issue_valid, issue_data1, issue_data2, issue_data3,
        input  issue_rm, issue_op, issue_opcode,
        input  cmpl_valid, cmpl_result, cmpl_flags,
        input  rec_ready,
        output rec_valid, rec_data
    );
endinterface

// File: rtl/fp_trace_packer.sv
// Passive FPU trace recorder: pairs in-order issues with completions and streams
// 156-bit test-vector records through an output FIFO.
module fp_trace_packer #(
    parameter int PEND_DEPTH = 4,
    parameter int OUT_DEPTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    fp_trace_packer_if.slave      bus,
    input  logic                  clear,
    output logic [31:0]           rec_count,
    output logic [15:0]           drop_count,
    output logic                  err_issue_ovf,
    output logic                  err_orphan
);
    localparam int PPW = $clog2(PEND_DEPTH);
    localparam int OPW = $clog2(OUT_DEPTH);
    localparam int PEW = 111;

    logic [PEW-1:0] pendMem_q [PEND_DEPTH];
    logic [PPW-1:0] pendWr_q, pendRd_q;
    logic [PPW:0]   pendCnt_q, pendCnt_d;
    logic [155:0]   outMem_q [OUT_DEPTH];
    logic [OPW-1:0] outWr_q, outRd_q;
    logic [OPW:0]   outCnt_q, outCnt_d;

    logic [31:0] recCount_q, recCount_d;
    logic [15:0] dropCount_q, dropCount_d;
    logic        errOvf_q, errOvf_d;
    logic        errOrphan_q, errOrphan_d;

    logic pendEmpty, pendFull, pendPop, pendPush;
    logic outEmpty, outFull, outPop, outPush;
    logic dropEvt, ovfEvt, orphanEvt;
    logic [PEW-1:0] pendHead;
    logic [155:0]   record;

    // Counts are one bit wider than the pointers, so the MSB alone flags "full".
    assign pendEmpty = (pendCnt_q == '0);
    assign pendFull  = pendCnt_q[PPW];
    assign outEmpty  = (outCnt_q == '0);
    assign outFull   = outCnt_q[OPW];

    assign pendPop   = bus.cmpl_valid && !pendEmpty;
    assign pendPush  = bus.issue_valid && (!pendFull || pendPop);
    assign outPop    = !outEmpty && bus.rec_ready;
    assign outPush   = pendPop && (!outFull || outPop);

    assign dropEvt   = pendPop && outFull && !outPop;
    assign ovfEvt    = bus.issue_valid && pendFull && !pendPop;
    assign orphanEvt = bus.cmpl_valid && pendEmpty;

    assign pendHead  = pendMem_q[pendRd_q];
    assign record    = {pendHead[110:15], bus.cmpl_result, 3'b000, bus.cmpl_flags,
                        1'b0, pendHead[14:12], 2'b00, pendHead[11:10], 2'b00, pendHead[9:0]};

    assign bus.rec_valid = !outEmpty;
    assign bus.rec_data  = outEmpty ? '0 : outMem_q[outRd_q];
    assign rec_count     = recCount_q;
    assign drop_count    = dropCount_q;
    assign err_issue_ovf = errOvf_q;
    assign err_orphan    = errOrphan_q;

    always_comb begin
        pendCnt_d   = pendCnt_q + {{PPW{1'b0}}, pendPush} - {{PPW{1'b0}}, pendPop};
        outCnt_d    = outCnt_q + {{OPW{1'b0}}, outPush} - {{OPW{1'b0}}, outPop};
        recCount_d  = recCount_q;
        dropCount_d = dropCount_q;
        errOvf_d    = errOvf_q;
        errOrphan_d = errOrphan_q;
        // A clear cycle masks every event seen by the counters and sticky bits.
        if (clear) begin
            recCount_d  = '0;
            dropCount_d = '0;
            errOvf_d    = 1'b0;
            errOrphan_d = 1'b0;
        end else begin
            if (outPop)
                recCount_d = recCount_q + 32'd1;
            if (dropEvt && (dropCount_q != 16'hFFFF))
                dropCount_d = dropCount_q + 16'd1;
            if (ovfEvt)
                errOvf_d = 1'b1;
            if (orphanEvt)
                errOrphan_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pendWr_q    <= '0;
            pendRd_q    <= '0;
            pendCnt_q   <= '0;
            outWr_q     <= '0;
            outRd_q     <= '0;
            outCnt_q    <= '0;
            recCount_q  <= '0;
            dropCount_q <= '0;
            errOvf_q    <= 1'b0;
            errOrphan_q <= 1'b0;
        end else begin
            if (pendPush) pendWr_q <= pendWr_q + 1'b1;
            if (pendPop)  pendRd_q <= pendRd_q + 1'b1;
            if (outPush)  outWr_q  <= outWr_q + 1'b1;
            if (outPop)   outRd_q  <= outRd_q + 1'b1;
            pendCnt_q   <= pendCnt_d;
            outCnt_q    <= outCnt_d;
            recCount_q  <= recCount_d;
            dropCount_q <= dropCount_d;
            errOvf_q    <= errOvf_d;
            errOrphan_q <= errOrphan_d;
        end
    end

    // Storage needs no reset: entries are only visible through the counted pointers.
    always_ff @(posedge clock) begin
        if (pendPush)
            pendMem_q[pendWr_q] <= {bus.issue_data1, bus.issue_data2, bus.issue_data3,
                                    bus.issue_rm, bus.issue_op, bus.issue_opcode};
        if (outPush)
            outMem_q[outWr_q] <= record;
    end
endmodule

// File: tb/tb_fp_trace_packer.sv
// Self-checking bench for fp_trace_packer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fp_trace_packer;
    localparam int PEND_DEPTH = 4;
    localparam int OUT_DEPTH  = 8;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [2:0]  rm;
        logic [1:0]  op;
        logic [9:0]  opcode;
    } issue_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] rec_count;
    logic [15:0] drop_count;
    logic        err_issue_ovf;
    logic        err_orphan;
    int          errors = 0;
    int          checks = 0;

    issue_t       pendQ[$];
    logic [155:0] outQ[$];
    int unsigned  mRecCount = 0;
    int           mDropCount = 0;
    bit           mOvf = 0;
    bit           mOrphan = 0;

    fp_trace_packer_if bus();

    fp_trace_packer #(.PEND_DEPTH(PEND_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clock(clock), .reset(reset), .bus(bus), .clear(clear),
        .rec_count(rec_count), .drop_count(drop_count),
        .err_issue_ovf(err_issue_ovf), .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    // Record assembled field by field from the documented bit positions.
    function automatic logic [155:0] makeRecord(issue_t e, logic [31:0] res, logic [4:0] fl);
        logic [155:0] r;
        r = '0;
        r[155:124] = e.d1;
        r[123:92]  = e.d2;
        r[91:60]   = e.d3;
        r[59:28]   = res;
        r[24:20]   = fl;
        r[18:16]   = e.rm;
        r[13:12]   = e.op;
        r[9:0]     = e.opcode;
        return r;
    endfunction

    function automatic logic [155:0] expRec();
        return (outQ.size() > 0) ? outQ[0] : 156'd0;
    endfunction

    function automatic issue_t randIssue(logic [9:0] opc);
        issue_t e;
        e.d1 = $urandom;
        e.d2 = $urandom;
        e.d3 = $urandom;
        e.rm = 3'($urandom_range(0, 7));
        e.op = 2'($urandom_range(0, 3));
        e.opcode = opc;
        return e;
    endfunction

    task automatic modelStep();
        bit accept;
        bit havePush;
        logic [155:0] newRec;
        issue_t h, n;
        if (!reset) begin
            pendQ.delete();
            outQ.delete();
            mRecCount = 0;
            mDropCount = 0;
            mOvf = 0;
            mOrphan = 0;
            return;
        end
        accept = (outQ.size() > 0) && bus.rec_ready;
        havePush = 0;
        newRec = '0;
        if (bus.cmpl_valid) begin
            if (pendQ.size() > 0) begin
                h = pendQ.pop_front();
                newRec = makeRecord(h, bus.cmpl_result, bus.cmpl_flags);
                if (outQ.size() < OUT_DEPTH || accept) havePush = 1;
                else if (!clear && mDropCount < 65535) mDropCount++;
            end else if (!clear) begin
                mOrphan = 1;
            end
        end
        if (bus.issue_valid) begin
            if (pendQ.size() < PEND_DEPTH) begin
                n.d1 = bus.issue_data1; n.d2 = bus.issue_data2; n.d3 = bus.issue_data3;
                n.rm = bus.issue_rm; n.op = bus.issue_op; n.opcode = bus.issue_opcode;
                pendQ.push_back(n);
            end else if (!clear) begin
                mOvf = 1;
            end
        end
        if (accept) begin
            void'(outQ.pop_front());
            if (!clear) mRecCount++;
        end
        if (havePush) outQ.push_back(newRec);
        if (clear) begin
            mRecCount = 0;
            mDropCount = 0;
            mOvf = 0;
            mOrphan = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic setIdle();
        bus.issue_valid = 1'b0;
        bus.cmpl_valid  = 1'b0;
    endtask

    task automatic driveIssue(issue_t e);
        bus.issue_valid  = 1'b1;
        bus.issue_data1  = e.d1;
        bus.issue_data2  = e.d2;
        bus.issue_data3  = e.d3;
        bus.issue_rm     = e.rm;
        bus.issue_op     = e.op;
        bus.issue_opcode = e.opcode;
    endtask

    task automatic driveCmpl(logic [31:0] res, logic [4:0] fl);
        bus.cmpl_valid  = 1'b1;
        bus.cmpl_result = res;
        bus.cmpl_flags  = fl;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL reset_rec_valid: got %b expected 0", bus.rec_valid); end
        checks++; if (bus.rec_data !== 156'd0) begin errors++; $display("FAIL reset_rec_data: got %h expected 0", bus.rec_data); end
        checks++; if (rec_count !== 32'd0) begin errors++; $display("FAIL reset_rec_count: got %0d expected 0", rec_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        checks++; if (err_issue_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_issue_ovf: got %b expected 0", err_issue_ovf); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b expected 0", err_orphan); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_fadd();
        issue_t e;
        logic [155:0] want;
        e.d1 = 32'h3F800000; e.d2 = 32'h40000000; e.d3 = 32'h0;
        e.rm = 3'd0; e.op = 2'd0; e.opcode = 10'h002;
        want = {32'h3F800000, 32'h40000000, 32'h00000000, 32'h40400000, 28'h0000002};
        driveIssue(e);
        tick();
        setIdle();
        tick();
        tick();
        driveCmpl(32'h40400000, 5'd0);
        tick();
        setIdle();
        checks++; if (bus.rec_valid !== 1'b1) begin errors++; $display("FAIL fadd_valid: got %b expected 1", bus.rec_valid); end
        checks++; if (bus.rec_data[59:28] !== 32'h40400000) begin errors++; $display("FAIL fadd_result: got %h expected 40400000", bus.rec_data[59:28]); end
        checks++; if (bus.rec_data[9:0] !== 10'h002) begin errors++; $display("FAIL fadd_opcode: got %h expected 002", bus.rec_data[9:0]); end
        checks++; if (bus.rec_data !== want) begin errors++; $display("FAIL fadd_record: got %h expected %h", bus.rec_data, want); end
        bus.rec_ready = 1'b1;
        tick();
        bus.rec_ready = 1'b0;
        checks++; if (rec_count !== 32'd1) begin errors++; $display("FAIL fadd_rec_count: got %0d expected 1", rec_count); end
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL fadd_drained: got %b expected 0", bus.rec_valid); end
    endtask

    task automatic test_in_order();
        issue_t ops[2];
        logic [31:0] res[2];
        logic [4:0] fl[2];
        logic [155:0] want;
        ops[0] = randIssue(10'h010);
        ops[1] = randIssue(10'h002);
        res[0] = 32'h3F000000;
        res[1] = 32'h40000000;
        fl[0] = 5'($urandom_range(0, 31));
        fl[1] = 5'($urandom_range(0, 31));
        driveIssue(ops[0]); tick();
        driveIssue(ops[1]); tick();
        setIdle(); tick();
        driveCmpl(res[0], fl[0]); tick();
        driveCmpl(res[1], fl[1]); tick();
        setIdle();
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            want = makeRecord(ops[k], res[k], fl[k]);
            checks++; if (bus.rec_valid !== 1'b1) begin errors++; $display("FAIL order_valid[%0d]: got %b expected 1", k, bus.rec_valid); end
            checks++; if (bus.rec_data !== want) begin errors++; $display("FAIL order_record[%0d]: got %h expected %h", k, bus.rec_data, want); end
            tick();
        end
        bus.rec_ready = 1'b0;
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL order_drained: got %b expected 0", bus.rec_valid); end
    endtask

    task automatic test_backpressure();
        issue_t ops[10];
        logic [31:0] res[10];
        logic [4:0] fl[10];
        logic [155:0] first, want;
        pulseClear();
        bus.rec_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ops[k] = randIssue(10'(1 << $urandom_range(0, 9)));
            res[k] = $urandom;
            fl[k] = 5'($urandom_range(0, 31));
        end
        first = makeRecord(ops[0], res[0], fl[0]);
        driveIssue(ops[0]);
        tick();
        for (int k = 1; k <= 10; k++) begin
            driveCmpl(res[k-1], fl[k-1]);
            if (k < 10) driveIssue(ops[k]);
            else bus.issue_valid = 1'b0;
            tick();
            checks++; if (bus.rec_data !== first) begin errors++; $display("FAIL bp_stable[%0d]: got %h expected %h", k, bus.rec_data, first); end
        end
        setIdle();
        tick();
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL bp_drop_count: got %0d expected 2", drop_count); end
        checks++; if (rec_count !== 32'd0) begin errors++; $display("FAIL bp_rec_count_held: got %0d expected 0", rec_count); end
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            want = makeRecord(ops[k], res[k], fl[k]);
            checks++; if (bus.rec_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %b expected 1", k, bus.rec_valid); end
            checks++; if (bus.rec_data !== want) begin errors++; $display("FAIL bp_drain_record[%0d]: got %h expected %h", k, bus.rec_data, want); end
            tick();
        end
        bus.rec_ready = 1'b0;
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", bus.rec_valid); end
        checks++; if (rec_count !== 32'd8) begin errors++; $display("FAIL bp_rec_count: got %0d expected 8", rec_count); end
    endtask

    task automatic test_pending_overflow();
        issue_t ops[5];
        logic [31:0] res[4];
        logic [155:0] want;
        pulseClear();
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ops[k] = randIssue(10'h008);
            driveIssue(ops[k]);
            tick();
        end
        setIdle();
        checks++; if (err_issue_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", err_issue_ovf); end
        for (int k = 0; k < 4; k++) begin
            res[k] = $urandom;
            driveCmpl(res[k], 5'd1);
            tick();
            want = makeRecord(ops[k], res[k], 5'd1);
            checks++; if (bus.rec_data !== want) begin errors++; $display("FAIL ovf_record[%0d]: got %h expected %h", k, bus.rec_data, want); end
        end
        setIdle();
        tick();
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_fifth: got %b expected 0", bus.rec_valid); end
        checks++; if (rec_count !== 32'd4) begin errors++; $display("FAIL ovf_rec_count: got %0d expected 4", rec_count); end
        driveCmpl($urandom, 5'd0);
        tick();
        setIdle();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL ovf_queue_empty: got %b expected 1", err_orphan); end
        tick();
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL ovf_orphan_no_record: got %b expected 0", bus.rec_valid); end
        bus.rec_ready = 1'b0;
    endtask

    task automatic test_orphan_clear();
        pulseClear();
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL clr_start: got %b expected 0", err_orphan); end
        driveCmpl(32'h12345678, 5'd0);
        tick();
        setIdle();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan); end
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL orphan_no_record: got %b expected 0", bus.rec_valid); end
        pulseClear();
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL clear_orphan: got %b expected 0", err_orphan); end
        checks++; if (rec_count !== 32'd0) begin errors++; $display("FAIL clear_rec_count: got %0d expected 0", rec_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL clear_drop_count: got %0d expected 0", drop_count); end
        checks++; if (err_issue_ovf !== 1'b0) begin errors++; $display("FAIL clear_ovf: got %b expected 0", err_issue_ovf); end
        clear = 1'b1;
        driveCmpl(32'h0, 5'd0);
        tick();
        clear = 1'b0;
        setIdle();
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL clear_masks_orphan: got %b expected 0", err_orphan); end
    endtask

    task automatic test_full_simul_reset();
        pulseClear();
        bus.rec_ready = 1'b0;
        for (int k = 0; k < PEND_DEPTH; k++) begin
            driveIssue(randIssue(10'h020));
            tick();
        end
        driveIssue(randIssue(10'h040));
        driveCmpl($urandom, 5'd3);
        tick();
        setIdle();
        checks++; if (err_issue_ovf !== 1'b0) begin errors++; $display("FAIL simul_no_ovf: got %b expected 0", err_issue_ovf); end
        checks++; if (bus.rec_valid !== 1'b1) begin errors++; $display("FAIL simul_record: got %b expected 1", bus.rec_valid); end
        driveIssue(randIssue(10'h080));
        tick();
        setIdle();
        checks++; if (err_issue_ovf !== 1'b1) begin errors++; $display("FAIL simul_still_full: got %b expected 1", err_issue_ovf); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", bus.rec_valid); end
        checks++; if (bus.rec_data !== 156'd0) begin errors++; $display("FAIL midreset_data: got %h expected 0", bus.rec_data); end
        checks++; if (rec_count !== 32'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL midreset_counts: got %0d/%0d expected 0/0", rec_count, drop_count); end
        checks++; if (err_issue_ovf !== 1'b0) begin errors++; $display("FAIL midreset_ovf: got %b expected 0", err_issue_ovf); end
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale[%0d]: got %b expected 0", k, bus.rec_valid); end
        end
        driveCmpl($urandom, 5'd0);
        tick();
        setIdle();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL midreset_pend_flushed: got %b expected 1", err_orphan); end
        checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_record: got %b expected 0", bus.rec_valid); end
        bus.rec_ready = 1'b0;
    endtask

    task automatic test_random();
        issue_t e;
        logic [155:0] want;
        pulseClear();
        for (int c = 0; c < 600; c++) begin
            e = randIssue(10'($urandom));
            driveIssue(e);
            bus.issue_valid = ($urandom_range(0, 99) < 45);
            driveCmpl($urandom, 5'($urandom_range(0, 31)));
            bus.cmpl_valid  = ($urandom_range(0, 99) < 40);
            bus.rec_ready   = (c % 100 < 40) ? 1'b0 : ($urandom_range(0, 99) < 70);
            clear           = ($urandom_range(0, 99) < 2);
            tick();
            want = expRec();
            checks++; if (bus.rec_valid !== (outQ.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, bus.rec_valid, outQ.size() > 0); end
            checks++; if (bus.rec_data !== want) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", c, bus.rec_data, want); end
            checks++; if (rec_count !== mRecCount) begin errors++; $display("FAIL rnd_rec_count@%0d: got %0d expected %0d", c, rec_count, mRecCount); end
            checks++; if (drop_count !== 16'(mDropCount)) begin errors++; $display("FAIL rnd_drop_count@%0d: got %0d expected %0d", c, drop_count, mDropCount); end
            checks++; if (err_issue_ovf !== mOvf) begin errors++; $display("FAIL rnd_ovf@%0d: got %b expected %b", c, err_issue_ovf, mOvf); end
            checks++; if (err_orphan !== mOrphan) begin errors++; $display("FAIL rnd_orphan@%0d: got %b expected %b", c, err_orphan, mOrphan); end
        end
        setIdle();
        clear = 1'b0;
        bus.rec_ready = 1'b0;
    endtask

    initial begin
        bus.issue_valid  = 1'b0;
        bus.issue_data1  = '0;
        bus.issue_data2  = '0;
        bus.issue_data3  = '0;
        bus.issue_rm     = '0;
        bus.issue_op     = '0;
        bus.issue_opcode = '0;
        bus.cmpl_valid   = 1'b0;
        bus.cmpl_result  = '0;
        bus.cmpl_flags   = '0;
        bus.rec_ready    = 1'b0;
        test_reset();
        test_single_fadd();
        test_in_order();
        test_backpressure();
        test_pending_overflow();
        test_orphan_clear();
        test_full_simul_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
